// File: rtl/fifo_pkt_reader_if.sv
// Handshake bundle for fifo_pkt_reader: upstream FIFO read port plus the
// framed valid/ready output stream.
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_sop, m_eop
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_sop, m_eop
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Drains fifo_sync into a framed valid/ready packet stream via a 2-entry prefetch buffer.
// Optional trailing XOR checksum beat per packet when FIFO_PKT_CHECKSUM_EN is defined.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_pkt_reader_if.master  bus,
  output logic [15:0]        pkt_count,
  output logic               busy
);

  localparam int            BW   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

`ifdef FIFO_PKT_CHECKSUM_EN
  typedef enum logic {S_DATA, S_CSUM} state_t;
`else
  typedef enum logic {S_DATA} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q;
  logic [BW-1:0]         beat_q, beat_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
`ifdef FIFO_PKT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                  push, pop, rd_en;
  logic                  valid, sop, eop;
  logic [DATA_WIDTH-1:0] data, head;
  logic [2:0]            occ;

  assign head = buf_mem_q[rd_ptr_q];
  assign push = inflight_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
`ifdef FIFO_PKT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    valid = 1'b0;
    data  = '0;
    sop   = 1'b0;
    eop   = 1'b0;
    pop   = 1'b0;
    case (state_q)
      S_DATA: begin
        valid = (buf_cnt_q != 2'd0);
        if (valid) begin
          data = head;
          sop  = (beat_q == '0);
`ifndef FIFO_PKT_CHECKSUM_EN
          eop  = (beat_q == LAST);
`endif
        end
        pop = valid && bus.m_ready;
        if (pop) begin
          beat_d = (beat_q == LAST) ? '0 : beat_q + BW'(1);
`ifdef FIFO_PKT_CHECKSUM_EN
          csum_d = csum_q ^ head;
          if (beat_q == LAST) state_d = S_CSUM;
`else
          if (beat_q == LAST) pkt_cnt_d = pkt_cnt_q + 16'd1;
`endif
        end
      end
`ifdef FIFO_PKT_CHECKSUM_EN
      S_CSUM: begin
        valid = 1'b1;
        data  = csum_q;
        eop   = 1'b1;
        if (bus.m_ready) begin
          csum_d    = '0;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = S_DATA;
        end
      end
`endif
      default: state_d = S_DATA;
    endcase
  end

  // Occupancy after this cycle's pop, counting the byte already in flight.
  assign occ       = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = rst_n && !bus.fifo_empty && (occ < 3'd2);
  assign buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_DATA;
      buf_mem_q[0] <= '0;
      buf_mem_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_cnt_q    <= 2'd0;
      inflight_q   <= 1'b0;
      beat_q       <= '0;
      pkt_cnt_q    <= 16'd0;
`ifdef FIFO_PKT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      buf_cnt_q  <= buf_cnt_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
`ifdef FIFO_PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      if (push) begin
        buf_mem_q[wr_ptr_q] <= bus.fifo_data;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = data;
  assign bus.m_sop      = sop;
  assign bus.m_eop      = eop;
  assign pkt_count      = pkt_cnt_q;
`ifdef FIFO_PKT_CHECKSUM_EN
  assign busy = (buf_cnt_q != 2'd0) || inflight_q || (beat_q != '0) || (state_q != S_DATA);
`else
  assign busy = (buf_cnt_q != 2'd0) || inflight_q || (beat_q != '0);
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: PKT_LEN=4 instance plus a PKT_LEN=1 instance.
module tb_fifo_pkt_reader;
  localparam int DW = 8;
`ifdef FIFO_PKT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus0 ();
  fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus1 ();
  logic [15:0] pkt0, pkt1;
  logic        busy0, busy1;

  fifo_pkt_reader #(.DATA_WIDTH(DW), .PKT_LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .pkt_count(pkt0), .busy(busy0));
  fifo_pkt_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .pkt_count(pkt1), .busy(busy1));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  logic [7:0] src0[$], src1[$];
  logic [9:0] exp0[$], exp1[$];
  int         mbeat0 = 0, mbeat1 = 0, mpkt0 = 0, mpkt1 = 0;
  logic [7:0] mcs0 = 8'h00, mcs1 = 8'h00;

  int cyc = 0;
  int rdy_mode = 0, phase = 0;
  int fall_cyc0 = -1, first_valid0 = -1, first_hs0 = -1, last_hs0 = -1;
  int rd_empty_viol = 0, occ_viol = 0, stab_viol = 0;
  logic rd0_s = 1'b0, rd1_s = 1'b0;
  logic stall0 = 1'b0, stall1 = 1'b0;
  logic [9:0] held0, held1;

  // Reference framing model: each byte yields a data beat, plus a checksum beat per packet if enabled.
  task automatic send(input int inst, input logic [7:0] b);
    int plen;
    plen = (inst == 0) ? 4 : 1;
    if (inst == 0) begin
      src0.push_back(b);
      exp0.push_back({b, mbeat0 == 0, !CSUM && (mbeat0 == plen - 1)});
      mcs0 = mcs0 ^ b;
      if (mbeat0 == plen - 1) begin
        if (CSUM) exp0.push_back({mcs0, 1'b0, 1'b1});
        mcs0 = 8'h00; mpkt0++; mbeat0 = 0;
      end else mbeat0++;
    end else begin
      src1.push_back(b);
      exp1.push_back({b, mbeat1 == 0, !CSUM && (mbeat1 == plen - 1)});
      mcs1 = mcs1 ^ b;
      if (mbeat1 == plen - 1) begin
        if (CSUM) exp1.push_back({mcs1, 1'b0, 1'b1});
        mcs1 = 8'h00; mpkt1++; mbeat1 = 0;
      end else mbeat1++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model and m_ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rd0_s) begin
      if (src0.size() > 0) bus0.fifo_data = src0.pop_front();
      else rd_empty_viol++;
    end
    if (rd1_s) begin
      if (src1.size() > 0) bus1.fifo_data = src1.pop_front();
      else rd_empty_viol++;
    end
    if (bus0.fifo_empty === 1'b1 && src0.size() > 0) fall_cyc0 = cyc;
    bus0.fifo_empty = (src0.size() == 0);
    bus1.fifo_empty = (src1.size() == 0);
    case (rdy_mode)
      1:       bus0.m_ready = (phase % 4 == 0) || (phase % 4 == 3);
      default: bus0.m_ready = 1'b1;
    endcase
    phase++;
    bus1.m_ready = 1'b1;
  end

  always @(negedge clk) begin
    rd0_s = bus0.fifo_rd_en;
    rd1_s = bus1.fifo_rd_en;
    if ((bus0.fifo_rd_en && bus0.fifo_empty) || (bus1.fifo_rd_en && bus1.fifo_empty)) rd_empty_viol++;
    if (u_dut0.buf_cnt_q > 2'd2 || u_dut1.buf_cnt_q > 2'd2) occ_viol++;
    if (rst_n) begin
      if (stall0 && (!bus0.m_valid || {bus0.m_data, bus0.m_sop, bus0.m_eop} !== held0)) stab_viol++;
      if (stall1 && (!bus1.m_valid || {bus1.m_data, bus1.m_sop, bus1.m_eop} !== held1)) stab_viol++;
      if (bus0.m_valid && first_valid0 < 0) first_valid0 = cyc;
      if (bus0.m_valid && bus0.m_ready) begin
        if (exp0.size() == 0) chk("unexpected_beat0", 1, 0);
        else chk("beat0", {bus0.m_data, bus0.m_sop, bus0.m_eop}, exp0.pop_front());
        if (first_hs0 < 0) first_hs0 = cyc;
        last_hs0 = cyc;
      end
      if (bus1.m_valid && bus1.m_ready) begin
        if (exp1.size() == 0) chk("unexpected_beat1", 1, 0);
        else chk("beat1", {bus1.m_data, bus1.m_sop, bus1.m_eop}, exp1.pop_front());
      end
      stall0 = bus0.m_valid && !bus0.m_ready;
      stall1 = bus1.m_valid && !bus1.m_ready;
      held0  = {bus0.m_data, bus0.m_sop, bus0.m_eop};
      held1  = {bus1.m_data, bus1.m_sop, bus1.m_eop};
    end else begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end
  end

  task automatic wait_drained();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (src0.size() == 0) && (src1.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0);
    end
    if (!done) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    mbeat0 = 0; mbeat1 = 0; mpkt0 = 0; mpkt1 = 0; mcs0 = 8'h00; mcs1 = 8'h00;
    @(negedge clk);
    chk("rst_rd_en", bus0.fifo_rd_en, 0);
    chk("rst_m_valid", bus0.m_valid, 0);
    chk("rst_m_data", bus0.m_data, 0);
    chk("rst_m_sop", bus0.m_sop, 0);
    chk("rst_m_eop", bus0.m_eop, 0);
    chk("rst_pkt_count", pkt0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_pkt_count1", pkt1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.fifo_empty = 1'b1; bus1.fifo_empty = 1'b1;
    bus0.fifo_data = '0; bus1.fifo_data = '0;
    bus0.m_ready = 1'b1; bus1.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    pulse_reset();

    // Back-to-back drain of two packets, plus read latency.
    first_valid0 = -1; first_hs0 = -1; fall_cyc0 = -1;
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    chk("nbeats_plan", exp0.size(), CSUM ? 10 : 8);
    wait_drained();
    chk("first_valid_latency", first_valid0 - fall_cyc0, 2);
    chk("back_to_back", last_hs0 - first_hs0, CSUM ? 9 : 7);
    chk("pkt_count_a", pkt0, mpkt0);

    // m_ready toggling 1,0,0,1.
    rdy_mode = 1; phase = 0;
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    wait_drained();
    rdy_mode = 0;
    chk("stall_stable", stab_viol, 0);
    chk("occupancy_le2", occ_viol, 0);
    chk("rd_en_while_empty", rd_empty_viol, 0);
    chk("pkt_count_b", pkt0, mpkt0);

    // FIFO runs dry mid-packet.
    send(0, 8'h21); send(0, 8'h22);
    wait_drained();
    chk("dry_m_valid", bus0.m_valid, 0);
    chk("dry_busy", busy0, 1);
    send(0, 8'h23); send(0, 8'h24);
    wait_drained();
    chk("pkt_count_c", pkt0, mpkt0);
    chk("idle_busy", busy0, 0);

    // Reset after 2 of 4 beats; next packet must restart with sop.
    send(0, 8'h31); send(0, 8'h32);
    wait_drained();
    chk("pre_reset_busy", busy0, 1);
    pulse_reset();
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h44); send(0, 8'h88);
    chk("csum_plan", exp0.size(), CSUM ? 5 : 4);
    wait_drained();
    chk("pkt_count_d", pkt0, 1);

    // PKT_LEN = 1 instance.
    send(1, 8'hA1); send(1, 8'hA2); send(1, 8'hA3);
    wait_drained();
    chk("pkt_count_len1", pkt1, 3);
    chk("final_rd_en_while_empty", rd_empty_viol, 0);
    chk("final_stall_stable", stab_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
